isp_stream_sequencer: RTL

//  Run-level controller in front of the ISP datapath in top.

---
 rtl/isp_stream_sequencer_pkg.sv | 36 +++
 rtl/isp_color_tracker.sv | 27 ++
 rtl/isp_stream_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/isp_stream_sequencer_pkg.sv
// Shared encodings for the ISP run sequencer: colour tags, operating modes, FSM states.
// Colour rotation helper used by both input and output tag trackers.
package isp_stream_sequencer_pkg;

    localparam int COLOR_BIT_CNT = 2;
    localparam int MODE_BIT_CNT  = 2;

    localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd0;
    localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd1;
    localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd2;
    localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd3;

    localparam logic [MODE_BIT_CNT-1:0] STAGE14 = 2'd1;
    localparam logic [MODE_BIT_CNT-1:0] STAGE56 = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    // VOID (or anything unexpected) restarts the rotation at RED
    function automatic logic [COLOR_BIT_CNT-1:0] next_color(input logic [COLOR_BIT_CNT-1:0] c);
        case (c)
            RED:     return GREEN;
            GREEN:   return BLUE;
            default: return RED;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [MODE_BIT_CNT-1:0] m);
        return (m == STAGE14) || (m == STAGE56);
    endfunction

endpackage

// File: rtl/isp_color_tracker.sv
// Expected-tag register for an R->G->B stream; flags mismatches combinationally.
// Latency: o_mismatch same cycle as i_beat; expectation updates next cycle. No backpressure.
module isp_color_tracker
    import isp_stream_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_beat,
    input  logic [COLOR_BIT_CNT-1:0] i_color,
    output logic                     o_mismatch
);

    logic [COLOR_BIT_CNT-1:0] r_expect;

    // Always resync to the received tag; on a match this equals the normal rotation
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_expect <= RED;
        end else if (i_beat) begin
            r_expect <= next_color(i_color);
        end
    end

    assign o_mismatch = i_beat & ((i_color == VOID) | (i_color != r_expect));

endmodule

// File: rtl/isp_stream_sequencer.sv
// Run-level controller: latches mode, gates input beats, tracks tags, counts pixels, ends frame.
// Latency: in_accept combinational, status registered one cycle. No backpressure generated.
// Optional perf_cyc cycle counter when ISP_SEQ_PERF_EN is defined.
module isp_stream_sequencer
    import isp_stream_sequencer_pkg::*;
#(
    parameter int IMG_ROW     = 1024,
    parameter int IMG_COL     = 1024,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MODE_BIT_CNT-1:0]  mode_in,
    input  logic                     valid_in,
    input  logic [COLOR_BIT_CNT-1:0] color_in,
    input  logic                     last_pic_in,
    input  logic                     dp_valid_out,
    input  logic [COLOR_BIT_CNT-1:0] dp_color_out,
    input  logic                     dp_last_pic_out,
    output logic                     in_accept,
    output logic                     stage14_en,
    output logic                     stage56_en,
    output logic                     busy,
    output logic                     finish_operation,
    output logic                     proto_err,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         pix_cnt
`ifdef ISP_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_cyc
`endif
);

    localparam int                TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W:0]    FRAME_PIX = (CNT_W + 1)'(IMG_ROW * IMG_COL);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    seq_state_t              r_state;
    seq_state_t              w_next_state;
    logic [MODE_BIT_CNT-1:0] r_mode;
    logic [CNT_W-1:0]        r_pix_cnt;
    logic [TO_W-1:0]         r_idle;
    logic                    r_proto_err;
    logic                    r_timeout_err;

    logic w_busy, w_can_start, w_start_ok, w_start_bad, w_acc;
    logic w_out_beat, w_blue, w_final_pos, w_final, w_last_err;
    logic w_in_beat, w_in14_err, w_timeout, w_in_mis, w_out_mis;

    assign w_busy      = (r_state == SEQ_RUN) | (r_state == SEQ_DRAIN);
    assign w_can_start = start & ((r_state == SEQ_IDLE) | (r_state == SEQ_DONE));
    assign w_start_ok  = w_can_start & mode_legal(mode_in);
    assign w_start_bad = w_can_start & ~mode_legal(mode_in);
    assign w_acc       = valid_in & (r_state == SEQ_RUN);

    // Output side is watched in RUN too: the datapath can emit before input ends
    assign w_out_beat  = dp_valid_out & w_busy;
    assign w_blue      = w_out_beat & (dp_color_out == BLUE);
    assign w_final_pos = w_blue & (({1'b0, r_pix_cnt} + 1'b1) == FRAME_PIX);
    assign w_final     = w_final_pos & dp_last_pic_out;
    assign w_last_err  = w_out_beat & dp_last_pic_out & ~w_final_pos;

    assign w_in_beat   = w_acc & (r_mode == STAGE56);
    assign w_in14_err  = w_acc & (r_mode == STAGE14) & (color_in != VOID);
    assign w_timeout   = (r_state == SEQ_DRAIN) & ~dp_valid_out & (r_idle == TO_LAST);

    isp_color_tracker u_in_trk (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start_ok),
        .i_beat     (w_in_beat),
        .i_color    (color_in),
        .o_mismatch (w_in_mis)
    );

    isp_color_tracker u_out_trk (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start_ok),
        .i_beat     (w_out_beat),
        .i_color    (dp_color_out),
        .o_mismatch (w_out_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SEQ_IDLE:  if (w_start_ok) w_next_state = SEQ_RUN;
            SEQ_RUN:   if (w_acc && last_pic_in) w_next_state = w_final ? SEQ_DONE : SEQ_DRAIN;
            SEQ_DRAIN: if (w_final || w_timeout) w_next_state = SEQ_DONE;
            SEQ_DONE:  if (w_start_ok) w_next_state = SEQ_RUN;
            default:   w_next_state = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode        <= '0;
            r_pix_cnt     <= '0;
            r_proto_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_mode        <= mode_in;
            r_pix_cnt     <= '0;
            r_proto_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_start_bad | w_in_mis | w_out_mis | w_in14_err | w_last_err) begin
                r_proto_err <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_blue && (r_pix_cnt != {CNT_W{1'b1}})) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != SEQ_DRAIN) || dp_valid_out) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

`ifdef ISP_SEQ_PERF_EN
    logic [31:0] r_perf_cyc;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_perf_cyc <= '0;
        end else if (w_busy && (r_perf_cyc != 32'hFFFF_FFFF)) begin
            r_perf_cyc <= r_perf_cyc + 32'd1;
        end
    end

    assign perf_cyc = r_perf_cyc;
`endif

    assign in_accept        = w_acc;
    assign busy             = w_busy;
    assign stage14_en       = w_busy & (r_mode == STAGE14);
    assign stage56_en       = w_busy & (r_mode == STAGE56);
    assign finish_operation = (r_state == SEQ_DONE);
    assign proto_err        = r_proto_err;
    assign timeout_err      = r_timeout_err;
    assign pix_cnt          = r_pix_cnt;

endmodule
